mas_rr_sched: RTL and testbench

Shared-resource scheduler for one modular add/subtract datapath. Arbitrates among NREQ requesters in round-robin order and accepts one request at a time. It then sequences the operation over two passes of a single internal adder. Pass 1 computes the raw a±b and its compare code against Q. Pass 2 applies the ±Q correction. The result is returned on a response channel with backpressure. It sits between the requesting engines and the modular arithmetic, replacing duplicated two-adder MAS instances.

---
 rtl/mas_rr_sched.sv | 216 +++++++++++++++++++++
 tb/tb_mas_rr_sched.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mas_rr_sched.sv
// Round-robin scheduler sharing one adder for modular add/subtract over two passes.
// Optional operand range checking is compiled in with `define MAS_RANGE_CHK_EN.
module mas_rr_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_op,
    input  logic [5*NREQ-1:0] req_a,
    input  logic [5*NREQ-1:0] req_b,
    input  logic [4:0]        q_mod,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [3:0]        rsp_dout,
    output logic [5:0]        rsp_tdout,
    output logic [1:0]        rsp_tcmp,
    output logic              rsp_err,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PASS1 = 2'd1,
        S_PASS2 = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] TC_NONE = 2'b00;
    localparam logic [1:0] TC_SUB  = 2'b01;
    localparam logic [1:0] TC_ADD  = 2'b10;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic            op_q, op_d;
    logic [4:0]      a_q, a_d;
    logic [4:0]      b_q, b_d;
    logic [4:0]      q_q, q_d;
    logic [5:0]      tmp_q, tmp_d;
    logic [1:0]      tcmp_q, tcmp_d;
    logic [3:0]      dout_q, dout_d;

    logic [4:0]      a_arr [NREQ];
    logic [4:0]      b_arr [NREQ];
    logic [IDW-1:0]  cand;
    logic [IDW-1:0]  win_idx;
    logic            found;
    logic [NREQ-1:0] grant;
    logic [4:0]      a_sel, b_sel;
    logic            op_sel;
    logic [5:0]      add_x, add_y, add_sum;
    logic            add_sub;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[5*gi +: 5];
            assign b_arr[gi] = req_b[5*gi +: 5];
        end
    endgenerate

    // Walk the requesters starting just after the last winner, wrapping at NREQ-1.
    always_comb begin
        cand    = ptr_q;
        win_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (cand == IDW'(NREQ - 1)) ? '0 : cand + 1'b1;
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
        grant = '0;
        if (found) begin
            grant[win_idx] = 1'b1;
        end
    end

    assign a_sel  = a_arr[win_idx];
    assign b_sel  = b_arr[win_idx];
    assign op_sel = req_op[win_idx];

    assign req_ready = (state_q == S_IDLE && rst_n) ? grant : '0;
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = id_q;
    assign rsp_dout  = dout_q;
    assign rsp_tdout = tmp_q;
    assign rsp_tcmp  = tcmp_q;

`ifdef MAS_RANGE_CHK_EN
    logic err_q, err_d;
    logic chk_bad;

    assign chk_bad = a_sel[4] | ($signed(a_sel) >= $signed(q_mod))
                   | b_sel[4] | ($signed(b_sel) >= $signed(q_mod))
                   | ($signed(q_mod) < $signed(5'd2));
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // Single shared adder: pass 1 forms a+/-b, pass 2 applies the Q correction.
    always_comb begin
        add_x   = {a_q[4], a_q};
        add_y   = {b_q[4], b_q};
        add_sub = op_q;
        if (state_q == S_PASS2) begin
            add_x   = tmp_q;
            add_sub = (tcmp_q == TC_SUB);
            add_y   = (tcmp_q == TC_NONE) ? 6'd0 : {q_q[4], q_q};
        end
        add_sum = add_sub ? (add_x - add_y) : (add_x + add_y);
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        q_d     = q_q;
        tmp_d   = tmp_q;
        tcmp_d  = tcmp_q;
        dout_d  = dout_q;
`ifdef MAS_RANGE_CHK_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    ptr_d   = win_idx;
                    id_d    = win_idx;
                    op_d    = op_sel;
                    a_d     = a_sel;
                    b_d     = b_sel;
                    q_d     = q_mod;
`ifdef MAS_RANGE_CHK_EN
                    err_d   = chk_bad;
`endif
                    state_d = S_PASS1;
                end
            end
            S_PASS1: begin
                tmp_d = add_sum;
                if ($signed(add_sum) >= $signed({q_q[4], q_q})) begin
                    tcmp_d = TC_SUB;
                end else if (add_sum[5]) begin
                    tcmp_d = TC_ADD;
                end else begin
                    tcmp_d = TC_NONE;
                end
`ifdef MAS_RANGE_CHK_EN
                if (err_q) begin
                    tmp_d  = '0;
                    tcmp_d = TC_NONE;
                end
`endif
                state_d = S_PASS2;
            end
            S_PASS2: begin
                dout_d = add_sum[3:0];
`ifdef MAS_RANGE_CHK_EN
                if (err_q) begin
                    dout_d = '0;
                end
`endif
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= IDW'(NREQ - 1);
            id_q    <= '0;
            op_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            q_q     <= '0;
            tmp_q   <= '0;
            tcmp_q  <= TC_NONE;
            dout_q  <= '0;
`ifdef MAS_RANGE_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            q_q     <= q_d;
            tmp_q   <= tmp_d;
            tcmp_q  <= tcmp_d;
            dout_q  <= dout_d;
`ifdef MAS_RANGE_CHK_EN
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_mas_rr_sched.sv
// Directed and randomized checks of mas_rr_sched against an arithmetic reference model.
module tb_mas_rr_sched;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
`ifdef MAS_RANGE_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_op;
    logic [5*NREQ-1:0] req_a;
    logic [5*NREQ-1:0] req_b;
    logic [4:0]        q_mod;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [3:0]        rsp_dout;
    logic [5:0]        rsp_tdout;
    logic [1:0]        rsp_tcmp;
    logic              rsp_err;
    logic              busy;

    int checks   = 0;
    int failures = 0;
    int m_ptr;
    int t_op [NREQ];
    int t_a  [NREQ];
    int t_b  [NREQ];
    int t_q;

    always #5 clk = ~clk;

    mas_rr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .q_mod     (q_mod),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_dout  (rsp_dout),
        .rsp_tdout (rsp_tdout),
        .rsp_tcmp  (rsp_tcmp),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_ops(input logic [NREQ-1:0] mask);
        req_valid = mask;
        for (int i = 0; i < NREQ; i++) begin
            req_op[i]      = t_op[i][0];
            req_a[5*i +: 5] = 5'(t_a[i]);
            req_b[5*i +: 5] = 5'(t_b[i]);
        end
        q_mod = 5'(t_q);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_busy"},      32'(busy), 0);
        chk({tag, "_req_ready"}, 32'(req_ready), 0);
        chk({tag, "_rsp_id"},    32'(rsp_id), 0);
        chk({tag, "_rsp_dout"},  32'(rsp_dout), 0);
        chk({tag, "_rsp_tdout"}, 32'(rsp_tdout), 0);
        chk({tag, "_rsp_tcmp"},  32'(rsp_tcmp), 0);
        chk({tag, "_rsp_err"},   32'(rsp_err), 0);
    endtask

    // One full transaction: grant, two passes, response (optionally stalled), handshake.
    task automatic run_txn(input logic [NREQ-1:0] mask, input int stall, output int won);
        int  w;
        int  a, b, q, tmp;
        int  e_tcmp, e_dout, e_tdout, e_err;
        bit  illegal, do_res;
        logic [NREQ-1:0] exp_g;

        @(negedge clk);
        drive_ops(mask);
        rsp_ready = (stall == 0);

        w = -1;
        for (int k = 1; k <= NREQ; k++) begin
            if (w < 0 && mask[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
        end
        exp_g = '0;
        if (w >= 0) exp_g[w] = 1'b1;

        a = t_a[w]; b = t_b[w]; q = t_q;
        tmp     = (t_op[w] != 0) ? a - b : a + b;
        illegal = (a < 0) || (a >= q) || (b < 0) || (b >= q) || (q < 2);
        do_res  = !illegal || CHK_EN;
        e_err   = (illegal && CHK_EN) ? 1 : 0;
        if (illegal && CHK_EN) begin
            e_tcmp = 0; e_dout = 0; e_tdout = 0;
        end else begin
            e_tcmp  = (tmp >= q) ? 1 : ((tmp < 0) ? 2 : 0);
            e_dout  = ((tmp % q) + q) % q;
            e_tdout = tmp & 63;
        end

        #1;
        chk("grant", 32'(req_ready), 32'(exp_g));
        won = -1;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) won = i;

        @(posedge clk); #1;
        m_ptr = w;
        q_mod = 5'($urandom_range(2, 15));
        chk("pass1_busy", 32'(busy), 1);
        chk("pass1_req_ready", 32'(req_ready), 0);
        chk("pass1_rsp_valid", 32'(rsp_valid), 0);

        @(posedge clk); #1;
        chk("pass2_rsp_valid", 32'(rsp_valid), 0);

        @(posedge clk); #1;
        chk("resp_valid", 32'(rsp_valid), 1);
        chk("resp_id", 32'(rsp_id), 32'(w));
        chk("resp_err", 32'(rsp_err), 32'(e_err));
        if (do_res) begin
            chk("resp_tdout", 32'(rsp_tdout), 32'(e_tdout));
            chk("resp_tcmp", 32'(rsp_tcmp), 32'(e_tcmp));
            chk("resp_dout", 32'(rsp_dout), 32'(e_dout));
        end

        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("stall_valid", 32'(rsp_valid), 1);
            chk("stall_busy", 32'(busy), 1);
            chk("stall_req_ready", 32'(req_ready), 0);
            chk("stall_id", 32'(rsp_id), 32'(w));
            if (do_res) begin
                chk("stall_dout", 32'(rsp_dout), 32'(e_dout));
                chk("stall_tdout", 32'(rsp_tdout), 32'(e_tdout));
                chk("stall_tcmp", 32'(rsp_tcmp), 32'(e_tcmp));
            end
        end
        rsp_ready = 1'b1;

        @(posedge clk); #1;
        chk("done_rsp_valid", 32'(rsp_valid), 0);
        chk("done_busy", 32'(busy), 0);
        $display("txn mask=%b id=%0d op=%0d a=%0d b=%0d q=%0d tmp=%0d dout=%0d tcmp=%0d err=%0d stall=%0d",
                 mask, w, t_op[w], a, b, q, tmp, e_dout, e_tcmp, e_err, stall);
    endtask

    initial begin
        int won;
        int order1 [6];
        int order2 [4];
        logic [NREQ-1:0] mask;

        order1 = '{0, 1, 2, 3, 0, 1};
        order2 = '{2, 3, 0, 2};

        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        q_mod     = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            t_op[i] = 0; t_a[i] = 0; t_b[i] = 0;
        end
        t_q = 7;

        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = NREQ - 1;

        // Directed arithmetic cases.
        t_op[0] = 0; t_a[0] = 5; t_b[0] = 4; t_q = 7;
        run_txn(4'b0001, 0, won);
        chk("tp1_winner", 32'(won), 0);
        t_op[2] = 1; t_a[2] = 2; t_b[2] = 5;
        run_txn(4'b0100, 0, won);
        chk("tp2_winner", 32'(won), 2);
        t_op[3] = 0; t_a[3] = 3; t_b[3] = 2;
        run_txn(4'b1000, 0, won);
        chk("tp2b_winner", 32'(won), 3);

        // Round-robin order with all requesters active, then with requester 1 dropped.
        for (int i = 0; i < NREQ; i++) begin
            t_op[i] = int'($urandom_range(0, 1));
            t_a[i]  = int'($urandom_range(0, 6));
            t_b[i]  = int'($urandom_range(0, 6));
        end
        for (int n = 0; n < 6; n++) begin
            run_txn(4'b1111, 0, won);
            chk("rr_all_order", 32'(won), 32'(order1[n]));
        end
        for (int n = 0; n < 4; n++) begin
            run_txn(4'b1101, 0, won);
            chk("rr_drop1_order", 32'(won), 32'(order2[n]));
        end

        // Backpressure held for five cycles.
        run_txn(4'b0010, 5, won);
        chk("stall_winner", 32'(won), 1);

        // Reset while PASS1 is in progress.
        @(negedge clk);
        drive_ops(4'b1111);
        @(posedge clk); #1;
        chk("pre_rst_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        req_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = NREQ - 1;
        repeat (4) begin
            @(posedge clk); #1;
            chk("post_rst_no_rsp", 32'(rsp_valid), 0);
        end
        run_txn(4'b1111, 0, won);
        chk("post_rst_first_grant", 32'(won), 0);

        // Out-of-range operand, then a legal one to confirm the error flag clears.
        t_op[1] = 0; t_a[1] = 9; t_b[1] = 0; t_q = 7;
        run_txn(4'b0010, 1, won);
        t_a[1] = 6; t_b[1] = 6;
        run_txn(4'b0010, 0, won);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 24; n++) begin
            t_q = int'($urandom_range(2, 15));
            for (int i = 0; i < NREQ; i++) begin
                t_op[i] = int'($urandom_range(0, 1));
                t_a[i]  = int'($urandom_range(0, t_q - 1));
                t_b[i]  = int'($urandom_range(0, t_q - 1));
            end
            mask = NREQ'($urandom_range(1, 15));
            run_txn(mask, int'($urandom_range(0, 2)), won);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
